spi_rx_module: RTL and testbench

- Receive-side counterpart of the 8-lane SPI transmitter.
- Deserialises eight parallel SPI data lanes that share one SPI clock and one active-low enable, and checks each 10-bit frame.
- Presents each received byte set to the FPGA fabric as a one-cycle strobe, with the last flag and error flags.
- Sits between the board-level SPI pins (loopback or a second FPGA) and the GMII packet builder.
- SPI inputs are oversampled in the system clock domain; no SPI-clocked flops.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_rx_module_if.sv | 38 +++
 rtl/spi_rx_sync.sv | 51 +++++
 rtl/spi_rx_module.sv | 147 ++++++++++++++
 tb/tb_spi_rx_module.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Frame layout and receiver state encoding for the 8-lane SPI link.
// The frame constants are shared by the transmitter and the receiver.
package spi_pkg;

  localparam int SPI_FRAME_W  = 10;
  localparam int SPI_BIT_LAST = 9;
  localparam int SPI_BIT_MARK = 8;
  localparam int SPI_LANES    = 8;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2
  } spi_rx_state_e;

endpackage

// File: rtl/spi_rx_module_if.sv
// Bundle of the SPI pins and the fabric-side word strobe of the receiver.
// The slave modport is the receiver's view; the master modport drives the pins.
interface spi_rx_module_if
  import spi_pkg::*;
#(
  parameter int pW_CNT = 16
) ();

  logic                 ispi_clk;
  logic                 ispi_enb;
  logic [SPI_LANES-1:0] ispi_di;

  logic                 ovalid;
  logic                 osop;
  logic                 olast;
  logic [7:0]           odata_1, odata_2, odata_3, odata_4;
  logic [7:0]           odata_5, odata_6, odata_7, odata_8;
  logic                 oerr_marker;
  logic                 oerr_frame;
  logic [pW_CNT-1:0]    ocnt_words;

  modport master (
    output ispi_clk, ispi_enb, ispi_di,
    input  ovalid, osop, olast,
    input  odata_1, odata_2, odata_3, odata_4,
    input  odata_5, odata_6, odata_7, odata_8,
    input  oerr_marker, oerr_frame, ocnt_words
  );

  modport slave (
    input  ispi_clk, ispi_enb, ispi_di,
    output ovalid, osop, olast,
    output odata_1, odata_2, odata_3, odata_4,
    output odata_5, odata_6, odata_7, odata_8,
    output oerr_marker, oerr_frame, ocnt_words
  );

endinterface

// File: rtl/spi_rx_sync.sv
// Synchronises SPI clock, enable and lane data into iclk and emits a
// registered rising-edge strobe aligned with the delayed enable and data.
module spi_rx_sync
  import spi_pkg::*;
#(
  parameter int pSYNC_STAGES = 2,
  parameter int pLANES       = SPI_LANES
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              ispi_clk,
  input  logic              ispi_enb,
  input  logic [pLANES-1:0] ispi_di,
  output logic              orise,
  output logic              osync_enb,
  output logic [pLANES-1:0] osync_di
);

  logic [pSYNC_STAGES-1:0] clk_sr;
  logic [pSYNC_STAGES-1:0] enb_sr;
  logic [pLANES-1:0]       di_sr [pSYNC_STAGES];
  logic                    clk_d;

  wire sync_clk = clk_sr[pSYNC_STAGES-1];
  wire sync_enb = enb_sr[pSYNC_STAGES-1];

  // Enable resets to "active" so a frame already running at reset release
  // is seen as busy until the line genuinely returns high.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge iclk) begin
    if (irst) begin
      clk_sr    <= '0;
      enb_sr    <= '0;
      clk_d     <= 1'b0;
      orise     <= 1'b0;
      osync_enb <= 1'b0;
      osync_di  <= '0;
      for (int i = 0; i < pSYNC_STAGES; i++) di_sr[i] <= '0;
    end else begin
      clk_sr    <= {clk_sr[pSYNC_STAGES-2:0], ispi_clk};
      enb_sr    <= {enb_sr[pSYNC_STAGES-2:0], ispi_enb};
      di_sr[0]  <= ispi_di;
      for (int i = 1; i < pSYNC_STAGES; i++) di_sr[i] <= di_sr[i-1];
      clk_d     <= sync_clk;
      orise     <= sync_clk & ~clk_d & ~sync_enb;
      osync_enb <= sync_enb;
      osync_di  <= di_sr[pSYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/spi_rx_module.sv
// 8-lane SPI receiver: oversampled deserialiser with per-word frame checks,
// sop/last tagging and a wrapping good-word counter.
module spi_rx_module
  import spi_pkg::*;
#(
  parameter int pW_DATA_SPI  = SPI_FRAME_W,
  parameter int pSYNC_STAGES = 2,
  parameter int pW_CNT       = 16
) (
  input logic             iclk,
  input logic             irst,
  spi_rx_module_if.slave  bus
);

  localparam int              W_BIT    = $clog2(pW_DATA_SPI);
  localparam logic [W_BIT-1:0] LAST_BIT = W_BIT'(pW_DATA_SPI - 1);

  logic                 rise, sync_enb;
  logic [SPI_LANES-1:0] sync_di;

  spi_rx_sync #(.pSYNC_STAGES(pSYNC_STAGES), .pLANES(SPI_LANES)) u_sync (
    .iclk     (iclk),
    .irst     (irst),
    .ispi_clk (bus.ispi_clk),
    .ispi_enb (bus.ispi_enb),
    .ispi_di  (bus.ispi_di),
    .orise    (rise),
    .osync_enb(sync_enb),
    .osync_di (sync_di)
  );

  spi_rx_state_e     state, state_nxt;
  logic              shift_en, word_end, start, frame_err;
  logic [W_BIT-1:0]  cnt_bit;

  always_ff @(posedge iclk) begin
    if (irst) state <= ST_WAIT_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no latch forms.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    word_end  = 1'b0;
    start     = 1'b0;
    frame_err = 1'b0;
    case (state)
      ST_WAIT_IDLE: if (sync_enb) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (!sync_enb) begin
          state_nxt = ST_SHIFT;
          start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rise) begin
          shift_en = 1'b1;
          word_end = (cnt_bit == LAST_BIT);
        end
        if (sync_enb) begin
          state_nxt = ST_IDLE;
          frame_err = (cnt_bit != '0) && !word_end;
        end
      end
      default: state_nxt = ST_WAIT_IDLE;
    endcase
  end

  // NOTE: shift registers carry no reset; they are only read after a full word.
  logic [pW_DATA_SPI-1:0] sr [SPI_LANES];

  always_ff @(posedge iclk) begin
    if (shift_en)
      for (int k = 0; k < SPI_LANES; k++)
        sr[k] <= {sr[k][pW_DATA_SPI-2:0], sync_di[k]};
  end

  logic word_ok;

  always_comb begin
    word_ok = 1'b1;
    for (int k = 0; k < SPI_LANES; k++)
      if (sr[k][SPI_BIT_MARK] || (sr[k][SPI_BIT_LAST] != sr[0][SPI_BIT_LAST]))
        word_ok = 1'b0;
  end

  logic              word_rdy, sop_pend;
  logic              valid_q, sop_q, last_q, err_mark_q, err_frame_q;
  logic [7:0]        odata_q [SPI_LANES];
  logic [pW_CNT-1:0] cnt_q;

  always_ff @(posedge iclk) begin
    if (irst) begin
      cnt_bit     <= '0;
      word_rdy    <= 1'b0;
      sop_pend    <= 1'b0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      last_q      <= 1'b0;
      err_mark_q  <= 1'b0;
      err_frame_q <= 1'b0;
      cnt_q       <= '0;
      for (int k = 0; k < SPI_LANES; k++) odata_q[k] <= '0;
    end else begin
      word_rdy    <= word_end;
      err_frame_q <= frame_err;
      valid_q     <= 1'b0;
      err_mark_q  <= 1'b0;

      if (start)         cnt_bit <= '0;
      else if (shift_en) cnt_bit <= word_end ? '0 : cnt_bit + W_BIT'(1);

      if (word_rdy) begin
        if (word_ok) begin
          valid_q <= 1'b1;
          sop_q   <= sop_pend;
          last_q  <= sr[0][SPI_BIT_LAST];
          cnt_q   <= cnt_q + pW_CNT'(1);
          for (int k = 0; k < SPI_LANES; k++) odata_q[k] <= sr[k][7:0];
        end else begin
          err_mark_q <= 1'b1;
        end
      end

      // A new enable window re-arms sop even if the old word is still being judged.
      if (start)                    sop_pend <= 1'b1;
      else if (word_rdy && word_ok) sop_pend <= 1'b0;
    end
  end

  assign bus.ovalid      = valid_q;
  assign bus.osop        = sop_q;
  assign bus.olast       = last_q;
  assign bus.odata_1     = odata_q[0];
  assign bus.odata_2     = odata_q[1];
  assign bus.odata_3     = odata_q[2];
  assign bus.odata_4     = odata_q[3];
  assign bus.odata_5     = odata_q[4];
  assign bus.odata_6     = odata_q[5];
  assign bus.odata_7     = odata_q[6];
  assign bus.odata_8     = odata_q[7];
  assign bus.oerr_marker = err_mark_q;
  assign bus.oerr_frame  = err_frame_q;
  assign bus.ocnt_words  = cnt_q;

endmodule

// File: tb/tb_spi_rx_module.sv
// Directed + randomised bench for spi_rx_module: a word-level model predicts
// strobes, error pulses, latency and counter values for two counter widths.
module tb_spi_rx_module;

  localparam int SYNC = 2;

  logic       iclk = 1'b0;
  logic       irst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_enb = 1'b1;
  logic [7:0] spi_di = '0;

  always #10 iclk = ~iclk;

  spi_rx_module_if #(.pW_CNT(16)) bus ();
  spi_rx_module_if #(.pW_CNT(4))  bus_s ();

  assign bus.ispi_clk   = spi_clk;
  assign bus.ispi_enb   = spi_enb;
  assign bus.ispi_di    = spi_di;
  assign bus_s.ispi_clk = spi_clk;
  assign bus_s.ispi_enb = spi_enb;
  assign bus_s.ispi_di  = spi_di;

  spi_rx_module #(.pW_DATA_SPI(10), .pSYNC_STAGES(SYNC), .pW_CNT(16)) dut (
    .iclk(iclk), .irst(irst), .bus(bus.slave)
  );

  spi_rx_module #(.pW_DATA_SPI(10), .pSYNC_STAGES(SYNC), .pW_CNT(4)) dut_s (
    .iclk(iclk), .irst(irst), .bus(bus_s.slave)
  );

  typedef struct packed {
    logic [7:0][7:0] d;
    logic            last;
    logic            sop;
    logic [15:0]     cnt;
    logic [31:0]     cyc;
  } word_t;

  word_t obs_q[$];
  word_t exp_q[$];
  int    cyc_cnt = 0;
  int    n_mark = 0, n_frame = 0;
  int    exp_mark = 0, exp_frame = 0;
  int    n_vec = 0, n_err = 0;
  int    t_rise = 0;
  bit    sop_m = 1'b0;
  int    cnt_m = 0;

  always @(posedge iclk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge iclk) begin
    if (bus.ovalid)
      obs_q.push_back('{d: {bus.odata_8, bus.odata_7, bus.odata_6, bus.odata_5,
                            bus.odata_4, bus.odata_3, bus.odata_2, bus.odata_1},
                        last: bus.olast, sop: bus.osop, cnt: bus.ocnt_words,
                        cyc: 32'(cyc_cnt)});
    if (bus.oerr_marker) n_mark++;
    if (bus.oerr_frame)  n_frame++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  // Word-level reference: a word is good iff no lane has the marker set and
  // all lanes agree on the last bit; ovalid lands SYNC+2 cycles after the
  // first edge that sees the 10th SPI clock high.
  task automatic model_word(input logic [7:0][9:0] w);
    bit good = 1'b1;
    word_t e;
    for (int k = 0; k < 8; k++)
      if (w[k][8] || (w[k][9] != w[0][9])) good = 1'b0;
    if (good) begin
      cnt_m++;
      for (int k = 0; k < 8; k++) e.d[k] = w[k][7:0];
      e.last = w[0][9];
      e.sop  = sop_m;
      e.cnt  = 16'(cnt_m);
      e.cyc  = 32'(t_rise + SYNC + 2);
      exp_q.push_back(e);
      sop_m = 1'b0;
    end else begin
      exp_mark++;
    end
  endtask

  task automatic send_bits(input logic [7:0][9:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      for (int k = 0; k < 8; k++) spi_di[k] = w[k][9-i];
      spi_clk = 1'b0;
      cyc(4);
      spi_clk = 1'b1;
      t_rise  = cyc_cnt + 1;
      cyc(4);
    end
    spi_clk = 1'b0;
    cyc(4);
  endtask

  task automatic send_word(input logic [7:0][9:0] w);
    send_bits(w, 10);
    model_word(w);
  endtask

  task automatic open_window();
    spi_enb = 1'b0;
    sop_m   = 1'b1;
    cyc(4);
  endtask

  task automatic close_window();
    spi_enb = 1'b1;
    cyc(8);
  endtask

  task automatic do_reset();
    irst = 1'b1;
    cyc(3);
    cnt_m = 0;
    sop_m = 1'b0;
    irst  = 1'b0;
  endtask

  function automatic logic [7:0][9:0] rand_word(input bit last);
    logic [7:0][9:0] w;
    for (int k = 0; k < 8; k++) w[k] = {last, 1'b0, 8'($urandom)};
    return w;
  endfunction

  task automatic compare_all(input string tag);
    word_t o, e;
    cyc(12);
    check({tag, " words"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      for (int k = 0; k < 8; k++)
        check($sformatf("%s odata_%0d", tag, k + 1), 32'(o.d[k]), 32'(e.d[k]));
      check({tag, " olast"}, 32'(o.last), 32'(e.last));
      check({tag, " osop"}, 32'(o.sop), 32'(e.sop));
      check({tag, " ocnt_words"}, 32'(o.cnt), 32'(e.cnt));
      check({tag, " latency"}, o.cyc, e.cyc);
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, " oerr_marker pulses"}, 32'(n_mark), 32'(exp_mark));
    check({tag, " oerr_frame pulses"}, 32'(n_frame), 32'(exp_frame));
    check({tag, " narrow counter"}, 32'(bus_s.ocnt_words), 32'(cnt_m % 16));
  endtask

  initial begin
    logic [7:0][9:0] w;

    // Reset with enable idle high
    cyc(5);
    check("reset ovalid", 32'(bus.ovalid), 0);
    check("reset osop", 32'(bus.osop), 0);
    check("reset olast", 32'(bus.olast), 0);
    check("reset odata_1", 32'(bus.odata_1), 0);
    check("reset odata_8", 32'(bus.odata_8), 0);
    check("reset errs", 32'({bus.oerr_marker, bus.oerr_frame}), 0);
    check("reset ocnt_words", 32'(bus.ocnt_words), 0);
    irst = 1'b0;
    cyc(8);

    // Single word, lane k = 0xA5 + k - 1, last set
    for (int k = 0; k < 8; k++) w[k] = {1'b1, 1'b0, 8'(8'hA5 + k)};
    open_window();
    send_word(w);
    close_window();
    compare_all("single");

    // Four back-to-back words in one window, last only on the fourth
    open_window();
    for (int n = 1; n <= 4; n++) begin
      w = rand_word(n == 4);
      w[0][7:0] = 8'(n);
      send_word(w);
    end
    close_window();
    compare_all("burst");

    // Marker on lane 5, then a clean word in the same window keeps sop
    open_window();
    w = rand_word(1'b0);
    w[4][8] = 1'b1;
    send_word(w);
    send_word(rand_word(1'b1));
    close_window();
    compare_all("marker");

    // Enable drops after 6 bits: frame error, then a fresh clean word
    open_window();
    send_bits(rand_word(1'b0), 6);
    exp_frame++;
    close_window();
    open_window();
    send_word(rand_word(1'b0));
    close_window();
    compare_all("partial");

    // Randomised windows with occasional marker / last-disagreement faults
    for (int win = 0; win < 5; win++) begin
      open_window();
      for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
        w = rand_word(1'($urandom));
        case ($urandom_range(0, 5))
          0: w[$urandom_range(0, 7)][8] = 1'b1;
          1: w[$urandom_range(1, 7)][9] = ~w[0][9];
          default: ;
        endcase
        send_word(w);
      end
      close_window();
    end
    compare_all("random");

    // Reset in the middle of a word with enable held low
    open_window();
    send_bits(rand_word(1'b0), 5);
    do_reset();
    send_bits(rand_word(1'b0), 10);
    compare_all("midreset hold");
    close_window();
    open_window();
    send_word(rand_word(1'b1));
    close_window();
    compare_all("midreset resume");

    // Counter wrap: narrow instance rolls over at 16, wide one keeps counting
    open_window();
    while (cnt_m < 16) send_word(rand_word(1'b0));
    close_window();
    compare_all("wrap");
    check("wrap narrow zero", 32'(bus_s.ocnt_words), 0);
    check("wrap wide", 32'(bus.ocnt_words), 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
